// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/response ports C and D plus the shared data memory port
interface dmem_arbiter_if;
  logic        c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [2:0]  c_width;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [2:0]  d_width;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_we;
  logic [2:0]  mem_width;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  modport slave (
    input  c_req, c_we, c_width, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, c_err,
    input  d_req, d_we, d_width, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_we, mem_width, mem_addr, mem_wdata,
    input  mem_rdata
  );
  modport master (
    output c_req, c_we, c_width, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, c_err,
    output d_req, d_we, d_width, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_we, mem_width, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin C/D arbiter with one-cycle memory access; DMEM_ARB_ALIGN_CHECK_EN adds misalignment faults
module dmem_arbiter #(
  parameter int unsigned DEPTH = 200
) (
  input logic            clk,
  input logic            rst_n,
  dmem_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, ACCESS} state_e;
  state_e      state_q, state_d;
  logic        last_q, last_d, sel, any_req, we_sel, misalign, err_d;
  logic [2:0]  width_sel, hold_width_q;
  logic [31:0] addr_sel, wdata_sel, hold_addr_q, hold_wdata_q, rdata_d;
  logic        hold_we_q, hold_port_q, hold_err_q;
  logic        c_rvalid_q, c_err_q, d_rvalid_q, d_err_q;
  logic [31:0] c_rdata_q, d_rdata_q;
  always_comb begin
    any_req   = bus.c_req | bus.d_req;
    sel       = bus.c_req & bus.d_req ? ~last_q : bus.d_req;
    we_sel    = sel ? bus.d_we : bus.c_we;
    width_sel = sel ? bus.d_width : bus.c_width;
    addr_sel  = sel ? bus.d_addr : bus.c_addr;
    wdata_sel = sel ? bus.d_wdata : bus.c_wdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    misalign  = (width_sel[1:0] == 2'b01 & addr_sel[0]) | (width_sel == 3'b010 & |addr_sel[1:0]);
`else
    misalign  = 1'b0;
`endif
    err_d     = (addr_sel[31:2] >= 30'(DEPTH)) | misalign;
    state_d   = state_q == IDLE ? (any_req ? ACCESS : IDLE) : IDLE;
    last_d    = state_q == IDLE & any_req ? sel : last_q;
    bus.c_gnt = state_q == IDLE & bus.c_req & ~sel;
    bus.d_gnt = state_q == IDLE & bus.d_req & sel;
    rdata_d   = hold_err_q | hold_we_q ? '0 : bus.mem_rdata;
  end
  // Hold register keeps driving the memory bus after the access, so mem_* stay stable in IDLE
  assign bus.mem_we    = state_q == ACCESS & hold_we_q & ~hold_err_q;
  assign bus.mem_width = hold_width_q;
  assign bus.mem_addr  = hold_addr_q;
  assign bus.mem_wdata = hold_wdata_q;
  assign bus.c_rvalid  = c_rvalid_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.c_err     = c_err_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_we_q    <= 1'b0;
      hold_port_q  <= 1'b0;
      hold_err_q   <= 1'b0;
      hold_width_q <= 3'b010;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else if (state_q == IDLE && any_req) begin
      hold_we_q    <= we_sel;
      hold_port_q  <= sel;
      hold_err_q   <= err_d;
      hold_width_q <= width_sel;
      hold_addr_q  <= addr_sel;
      hold_wdata_q <= wdata_sel;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      c_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      c_rvalid_q <= 1'b0;
      c_err_q    <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      if (state_q == ACCESS && !hold_port_q) begin
        c_rvalid_q <= 1'b1;
        c_err_q    <= hold_err_q;
        c_rdata_q  <= rdata_d;
      end
      if (state_q == ACCESS && hold_port_q) begin
        d_rvalid_q <= 1'b1;
        d_err_q    <= hold_err_q;
        d_rdata_q  <= rdata_d;
      end
    end
endmodule
